sequence_playback: RTL and testbench
====================================

Name: sequence_playback

Overview:
- Downstream stage of the level generator: replays the stored move sequence to the player before input is accepted.
- Reads one-hot move codes from the level BRAM at addresses 0..levelNum/2, the same range the generator writes.
- Shows each code on the 16-tile display for a fixed on-time, then blanks the display for a gap.
- Pulses done so the top-level FSM can hand over to the input checker.

Parameters:
ON_CYCLES, 25000000, cycles each move is displayed (>=1)
OFF_CYCLES, 12500000, cycles of blank display after each move (>=1)
READ_LATENCY, 1, BRAM cycles from address to valid q (>=1)

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-high; clears all state immediately
start  in  1  begin playback; sampled only in IDLE
levelNum  in  5  current level; totalMoves = levelNum>>1 (floor), latched on start
rdAddress  out  5  BRAM read address (registered)
rdData  in  16  BRAM read data (one-hot move code)
tileOut  out  16  tile/LED drive; one-hot during SHOW, 0 otherwise
moveIndex  out  5  index of move currently fetched/shown
busy  out  1  high in every state except IDLE
done  out  1  single-cycle pulse after the last gap

Behaviour:
- Reset (async): state=IDLE; rdAddress=0, moveIndex=0, tileOut=0, busy=0, done=0; timer=0; latched totalMoves=0.
- States: IDLE, FETCH, SHOW, GAP, FINISH.
- IDLE: start=1 -> latch totalMoves=levelNum>>1, moveIndex=0, rdAddress=0, go FETCH. start=0 -> stay in IDLE.
- FETCH:
  - Lasts READ_LATENCY+1 cycles; rdAddress equals moveIndex throughout.
  - At the edge ending the last FETCH cycle, rdData is captured into the display register and the state goes to SHOW.
  - tileOut=0 during FETCH.
- SHOW: tileOut = captured code for exactly ON_CYCLES cycles, then GAP.
- GAP:
  - tileOut=0 for exactly OFF_CYCLES cycles.
  - At the end of the last GAP cycle: if moveIndex==totalMoves, go FINISH.
  - Otherwise moveIndex and rdAddress increment by 1 and the state goes to FETCH.
- FINISH: done=1 for one cycle; busy=1 in this cycle; next state IDLE. moveIndex holds its final value until the next start.
- Per-move cost P = READ_LATENCY+1+ON_CYCLES+OFF_CYCLES.
  - Playback covers totalMoves+1 moves.
  - Take the first cycle after start is sampled as cycle 1. done is high in cycle (totalMoves+1)*P+1.
- Timer: one down/up counter, width clog2(max(ON_CYCLES,OFF_CYCLES,READ_LATENCY+1))+1, reloaded on every state entry; no free-running drift.
- Captured codes are displayed as-is; no one-hot checking (the generator guarantees validity).
- Boundaries:
  - levelNum=0 or 1 -> exactly one move (address 0).
  - levelNum=31 -> 16 moves (addresses 0..15). moveIndex never exceeds 15 and never wraps.
- start while busy (including the FINISH cycle) is ignored. levelNum changes after start are ignored until the next start.
- done and start in the same cycle: the start is ignored. A start in the following IDLE cycle is accepted.
- Reset mid-operation (any state): outputs return to reset values asynchronously, with no done pulse. The next start replays from address 0.
- No BRAM writes from this block; it never drives write enable.

Test Plan:
(All with ON_CYCLES=4, OFF_CYCLES=2, READ_LATENCY=1, so P=8; BRAM model has 1-cycle read latency.)
1. Assert reset with no clock edge -> tileOut=0, busy=0, done=0, rdAddress=0 immediately; held until release.
2. mem[0]=0x0001, levelNum=0, start pulse -> rdAddress=0; tileOut=0x0001 in cycles 3-6; tileOut=0 in cycles 7-8; done=1 only in cycle 9; busy=0 in cycle 10.
3. mem[0..3]=0x0008,0x0100,0x0002,0x8000, levelNum=7 -> four SHOW windows in that order, each 4 cycles, 8-cycle spacing; rdAddress 0,1,2,3; done in cycle 33.
4. Start a levelNum=7 playback; during SHOW of move 1, pulse start and change levelNum to 0 -> sequence unaffected, still 4 moves, done in cycle 33.
5. Assert reset during SHOW of move 2 (levelNum=7) -> tileOut=0 and busy=0 immediately with no done pulse; then start with levelNum=2 -> plays mem[0],mem[1] and done in cycle 17.
6. levelNum=31, mem[i]=1<<i -> 16 moves with tileOut 0x0001..0x8000 in order; moveIndex ends at 15 with no wrap; done in cycle 129.

Source files
------------

// File: rtl/sequence_playback.sv
// Replays the stored move sequence from the level BRAM onto the tile display.
// Each move is fetched, shown for ON_CYCLES, then blanked for OFF_CYCLES; done pulses at the end.
module sequence_playback #(
   parameter int ON_CYCLES    = 25000000,
   parameter int OFF_CYCLES   = 12500000,
   parameter int READ_LATENCY = 1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic [4:0]  levelNum,
   output logic [4:0]  rdAddress,
   input  logic [15:0] rdData,
   output logic [15:0] tileOut,
   output logic [4:0]  moveIndex,
   output logic        busy,
   output logic        done
);

   localparam int MAX_ONOFF = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
   localparam int MAX_TIME  = (MAX_ONOFF > READ_LATENCY + 1) ? MAX_ONOFF : READ_LATENCY + 1;
   localparam int TW        = $clog2(MAX_TIME) + 1;

   // Timer loads hold "cycles remaining minus one"; a state ends when the timer reads zero.
   localparam logic [TW-1:0] T_FETCH = TW'(READ_LATENCY);
   localparam logic [TW-1:0] T_SHOW  = TW'(ON_CYCLES - 1);
   localparam logic [TW-1:0] T_GAP   = TW'(OFF_CYCLES - 1);

   typedef enum logic [2:0] {IDLE, FETCH, SHOW, GAP, FINISH} state_t;

   state_t         state_reg, state_next;
   logic [TW-1:0]  timer_reg, timer_next;
   logic [4:0]     move_reg, move_next;
   logic [4:0]     addr_reg, addr_next;
   logic [3:0]     total_reg, total_next;
   logic [15:0]    disp_reg, disp_next;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_reg <= IDLE;
         timer_reg <= '0;
         move_reg  <= '0;
         addr_reg  <= '0;
         total_reg <= '0;
         disp_reg  <= '0;
      end else begin
         state_reg <= state_next;
         timer_reg <= timer_next;
         move_reg  <= move_next;
         addr_reg  <= addr_next;
         total_reg <= total_next;
         disp_reg  <= disp_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      timer_next = timer_reg;
      move_next  = move_reg;
      addr_next  = addr_reg;
      total_next = total_reg;
      disp_next  = disp_reg;
      unique case (state_reg)
         IDLE: begin
            if (start) begin
               total_next = 4'(levelNum >> 1);
               move_next  = '0;
               addr_next  = '0;
               timer_next = T_FETCH;
               state_next = FETCH;
            end
         end
         FETCH: begin
            if (timer_reg == '0) begin
               disp_next  = rdData;
               timer_next = T_SHOW;
               state_next = SHOW;
            end else begin
               timer_next = timer_reg - TW'(1);
            end
         end
         SHOW: begin
            if (timer_reg == '0) begin
               timer_next = T_GAP;
               state_next = GAP;
            end else begin
               timer_next = timer_reg - TW'(1);
            end
         end
         GAP: begin
            if (timer_reg == '0) begin
               // totalMoves+1 moves are played, so the last one has index totalMoves.
               if (move_reg == {1'b0, total_reg}) begin
                  timer_next = '0;
                  state_next = FINISH;
               end else begin
                  move_next  = move_reg + 5'd1;
                  addr_next  = addr_reg + 5'd1;
                  timer_next = T_FETCH;
                  state_next = FETCH;
               end
            end else begin
               timer_next = timer_reg - TW'(1);
            end
         end
         FINISH: begin
            timer_next = '0;
            state_next = IDLE;
         end
         default: begin
            timer_next = '0;
            state_next = IDLE;
         end
      endcase
   end

   assign tileOut   = (state_reg == SHOW) ? disp_reg : 16'h0000;
   assign busy      = (state_reg != IDLE);
   assign done      = (state_reg == FINISH);
   assign moveIndex = move_reg;
   assign rdAddress = addr_reg;

endmodule

// File: tb/tb_sequence_playback.sv
// Bench for sequence_playback: table of directed playbacks, random playbacks, and reset corner cases,
// all checked cycle by cycle against an arithmetic model of the playback timeline.
module tb_sequence_playback;

   localparam int ON  = 4;
   localparam int OFF = 2;
   localparam int RL  = 1;
   localparam int P   = RL + 1 + ON + OFF;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [4:0]  level_num;
   logic [4:0]  rd_address;
   logic [15:0] rd_data;
   logic [15:0] tile_out;
   logic [4:0]  move_index;
   logic        busy;
   logic        done;

   logic [15:0] mem [32];

   int checks = 0;
   int fails  = 0;

   sequence_playback #(.ON_CYCLES(ON), .OFF_CYCLES(OFF), .READ_LATENCY(RL)) dut (
      .clock(clk), .reset(rst), .start(start), .levelNum(level_num),
      .rdAddress(rd_address), .rdData(rd_data), .tileOut(tile_out),
      .moveIndex(move_index), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // BRAM with one cycle of read latency
   always @(posedge clk) rd_data <= mem[rd_address];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic set_pattern(input int pat);
      for (int i = 0; i < 32; i++) mem[i] = 16'h0001 << (i % 16);
      if (pat == 1) begin
         mem[0] = 16'h0008; mem[1] = 16'h0100; mem[2] = 16'h0002; mem[3] = 16'h8000;
      end
   endtask

   // Starts a playback at the current negedge and checks every cycle against the timeline model.
   // poke>0 raises start with levelNum=poke_lvl during cycle poke (must be ignored).
   task automatic run(input logic [4:0] lvl, input int poke, input logic [4:0] poke_lvl,
                      output int done_at, output logic [4:0] final_idx);
      logic [15:0] snap [32];
      int t, d, k, ph;
      logic [15:0] e_tile;
      logic [4:0]  e_idx;
      logic        e_busy, e_done;
      for (int i = 0; i < 32; i++) snap[i] = mem[i];
      t = int'(lvl) / 2;
      d = (t + 1) * P + 1;
      done_at = -1;
      final_idx = '0;
      level_num = lvl;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      for (int c = 1; c <= d + 1; c++) begin
         if (c < d) begin
            k = (c - 1) / P;
            ph = (c - 1) % P;
            e_idx  = 5'(k);
            e_tile = (ph >= RL + 1 && ph < RL + 1 + ON) ? snap[k] : 16'h0000;
            e_busy = 1'b1;
            e_done = 1'b0;
         end else begin
            e_idx  = 5'(t);
            e_tile = 16'h0000;
            e_busy = (c == d);
            e_done = (c == d);
         end
         check("tileOut", 32'(tile_out), 32'(e_tile));
         check("rdAddress", 32'(rd_address), 32'(e_idx));
         check("moveIndex", 32'(move_index), 32'(e_idx));
         check("busy", 32'(busy), 32'(e_busy));
         check("done", 32'(done), 32'(e_done));
         if (done === 1'b1 && done_at < 0) done_at = c;
         final_idx = move_index;
         if (c == poke) begin
            start = 1'b1;
            level_num = poke_lvl;
         end else begin
            start = 1'b0;
         end
         if (c <= d) @(negedge clk);
      end
      start = 1'b0;
   endtask

   typedef struct {
      logic [4:0] lvl;
      int         pat;
      int         poke;
      logic [4:0] poke_lvl;
      int         exp_done;
      logic [4:0] exp_final;
   } vec_t;

   vec_t vecs [7];

   initial begin
      int done_at;
      logic [4:0] fin;
      logic [4:0] lvl;
      int poke;

      vecs[0] = '{5'd0,  0, 0,  5'd0,  9,   5'd0};
      vecs[1] = '{5'd1,  0, 0,  5'd0,  9,   5'd0};
      vecs[2] = '{5'd7,  1, 0,  5'd0,  33,  5'd3};
      vecs[3] = '{5'd7,  1, 12, 5'd0,  33,  5'd3};
      vecs[4] = '{5'd2,  1, 17, 5'd31, 17,  5'd1};
      vecs[5] = '{5'd31, 0, 0,  5'd0,  129, 5'd15};
      vecs[6] = '{5'd10, 0, 40, 5'd3,  49,  5'd5};

      // Reset asserted before any clock edge: outputs must already be at reset values.
      set_pattern(0);
      rst = 1'b1;
      start = 1'b0;
      level_num = 5'd0;
      #1;
      check("rst0_tileOut", 32'(tile_out), 32'h0);
      check("rst0_busy", 32'(busy), 32'h0);
      check("rst0_done", 32'(done), 32'h0);
      check("rst0_rdAddress", 32'(rd_address), 32'h0);
      check("rst0_moveIndex", 32'(move_index), 32'h0);
      repeat (2) @(negedge clk);
      check("rst_hold_busy", 32'(busy), 32'h0);
      rst = 1'b0;
      @(negedge clk);

      // Start=0 in IDLE must not begin playback.
      check("idle_busy", 32'(busy), 32'h0);

      for (int v = 0; v < 7; v++) begin
         set_pattern(vecs[v].pat);
         run(vecs[v].lvl, vecs[v].poke, vecs[v].poke_lvl, done_at, fin);
         $display("vector %0d: levelNum=%0d done at cycle %0d final moveIndex=%0d",
                  v, vecs[v].lvl, done_at, fin);
         check("vec_done_cycle", 32'(done_at), 32'(vecs[v].exp_done));
         check("vec_final_index", 32'(fin), 32'(vecs[v].exp_final));
      end

      // Reset during SHOW of move 2: immediate clear, no done pulse, then fresh replay from 0.
      set_pattern(1);
      level_num = 5'd7;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (19) @(negedge clk);
      check("pre_rst_tile", 32'(tile_out), 32'h0002);
      check("pre_rst_index", 32'(move_index), 32'h2);
      rst = 1'b1;
      #1;
      check("mid_rst_tile", 32'(tile_out), 32'h0);
      check("mid_rst_busy", 32'(busy), 32'h0);
      check("mid_rst_done", 32'(done), 32'h0);
      check("mid_rst_rdAddress", 32'(rd_address), 32'h0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("rst_no_done", 32'(done), 32'h0);
      end
      rst = 1'b0;
      @(negedge clk);
      run(5'd2, 0, 5'd0, done_at, fin);
      $display("post-reset replay: levelNum=2 done at cycle %0d", done_at);
      check("post_rst_done_cycle", 32'(done_at), 32'd17);

      // Random playbacks with random one-hot contents and ignored mid-run starts.
      for (int r = 0; r < 20; r++) begin
         for (int i = 0; i < 32; i++) mem[i] = 16'h0001 << $urandom_range(0, 15);
         lvl = 5'($urandom_range(0, 31));
         poke = $urandom_range(0, (int'(lvl) / 2 + 1) * P + 1);
         run(lvl, poke, 5'($urandom_range(0, 31)), done_at, fin);
         $display("random %0d: levelNum=%0d poke=%0d done at cycle %0d", r, lvl, poke, done_at);
         check("rand_done_cycle", 32'(done_at), 32'((int'(lvl) / 2 + 1) * P + 1));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
